// File: rtl/axis_pkt_codec.sv
// AXI-Stream packet framer: ingress strips/validates a fixed-size header and forwards
// the announced payload; egress prepends a caller header or sends a header-only notice.
//
// rx state | meaning
// ---------+-------------------------------------------------------------
// RX_HDR   | collecting header words into the shadow
// RX_PAY   | pass-through of exactly addr_count payload beats
// RX_DROP  | discarding the rest of a bad packet up to its tlast
//
// tx state | meaning
// ---------+-------------------------------------------------------------
// TX_IDLE  | waiting for tx_start
// TX_HDRO  | emitting the latched header words
// TX_PAY   | pass-through of read data until r_axis tlast
module axis_pkt_codec #(
   parameter int             DATA_WIDTH = 16,
   parameter int             HDR_WORDS  = 6,
   parameter logic [15:0]    MAGIC      = 16'hC0DE,
   parameter int             BIDX_W     = 5
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [DATA_WIDTH-1:0]             p_axis_tdata,
   output logic                              p_axis_tvalid,
   input  logic                              p_axis_tready,
   output logic                              p_axis_tlast,
   output logic                              cmd_valid,
   output logic [7:0]                        cmd_instr,
   output logic [BIDX_W-1:0]                 cmd_bram_start,
   output logic [BIDX_W-1:0]                 cmd_bram_end,
   output logic [15:0]                       cmd_addr_start,
   output logic [15:0]                       cmd_addr_count,
   output logic [15:0]                       cmd_tag,
   output logic                              err_magic,
   output logic                              err_short_hdr,
   output logic                              err_len_short,
   output logic                              err_len_long,
   output logic [1:0]                        rx_state,
   input  logic [HDR_WORDS*DATA_WIDTH-1:0]   tx_hdr_flat,
   input  logic                              tx_start,
   input  logic                              tx_notify_only,
   output logic                              tx_busy,
   input  logic [DATA_WIDTH-1:0]             r_axis_tdata,
   input  logic                              r_axis_tvalid,
   output logic                              r_axis_tready,
   input  logic                              r_axis_tlast,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
);

   localparam int            HW       = $clog2(HDR_WORDS);
   localparam logic [HW-1:0] HDR_LAST = HW'(HDR_WORDS - 1);

   typedef enum logic [1:0] {RX_HDR = 2'd0, RX_PAY = 2'd1, RX_DROP = 2'd2} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HDRO = 2'd1, TX_PAY = 2'd2} tx_state_t;

   rx_state_t rx_q, rx_d;
   logic [HW-1:0]     hidx_q, hidx_d;
   logic [15:0]       rem_q, rem_d;
   logic [7:0]        w1_q;
   logic [BIDX_W-1:0] bs_q, be_q;
   logic [15:0]       w3_q, w4_q, w5_q;
   logic [15:0]       tag_w;
   logic              s_beat;
   logic              cmd_load, e_magic, e_short, e_ls, e_ll;

   tx_state_t tx_q, tx_d;
   logic [HW-1:0]           kidx_q, kidx_d;
   logic                    notify_q;
   logic [DATA_WIDTH-1:0]   tx_hdr_q [HDR_WORDS];
   logic                    m_beat;

   assign s_beat   = s_axis_tvalid && s_axis_tready;
   assign m_beat   = m_axis_tvalid && m_axis_tready;
   assign rx_state = rx_q;
   assign tx_busy  = aresetn && (tx_q != TX_IDLE);
   // With exactly six words the tag arrives on the closing beat itself
   assign tag_w    = (HDR_WORDS == 6) ? s_axis_tdata[15:0] : w5_q;

   // ---------------- ingress ----------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rx_q           <= RX_HDR;
         hidx_q         <= '0;
         rem_q          <= '0;
         w1_q           <= '0;
         bs_q           <= '0;
         be_q           <= '0;
         w3_q           <= '0;
         w4_q           <= '0;
         w5_q           <= '0;
         cmd_valid      <= 1'b0;
         cmd_instr      <= '0;
         cmd_bram_start <= '0;
         cmd_bram_end   <= '0;
         cmd_addr_start <= '0;
         cmd_addr_count <= '0;
         cmd_tag        <= '0;
         err_magic      <= 1'b0;
         err_short_hdr  <= 1'b0;
         err_len_short  <= 1'b0;
         err_len_long   <= 1'b0;
      end else begin
         rx_q          <= rx_d;
         hidx_q        <= hidx_d;
         rem_q         <= rem_d;
         cmd_valid     <= cmd_load;
         err_magic     <= e_magic;
         err_short_hdr <= e_short;
         err_len_short <= e_ls;
         err_len_long  <= e_ll;
         if (rx_q == RX_HDR && s_beat) begin
            if (hidx_q == HW'(1)) w1_q <= s_axis_tdata[7:0];
            if (hidx_q == HW'(2)) begin
               bs_q <= s_axis_tdata[BIDX_W-1:0];
               be_q <= BIDX_W'(s_axis_tdata >> BIDX_W);
            end
            if (hidx_q == HW'(3)) w3_q <= s_axis_tdata[15:0];
            if (hidx_q == HW'(4)) w4_q <= s_axis_tdata[15:0];
            if (hidx_q == HW'(5)) w5_q <= s_axis_tdata[15:0];
         end
         if (cmd_load) begin
            cmd_instr      <= w1_q;
            cmd_bram_start <= bs_q;
            cmd_bram_end   <= be_q;
            cmd_addr_start <= w3_q;
            cmd_addr_count <= w4_q;
            cmd_tag        <= tag_w;
         end
      end
   end

   always_comb begin
      rx_d     = rx_q;
      hidx_d   = hidx_q;
      rem_d    = rem_q;
      cmd_load = 1'b0;
      e_magic  = 1'b0;
      e_short  = 1'b0;
      e_ls     = 1'b0;
      e_ll     = 1'b0;
      case (rx_q)
         RX_HDR: if (s_beat) begin
            hidx_d = hidx_q + 1'b1;
            if (hidx_q == '0 && s_axis_tdata[15:0] != MAGIC) begin
               e_magic = 1'b1;
               hidx_d  = '0;
               rx_d    = s_axis_tlast ? RX_HDR : RX_DROP;
            end else if (hidx_q == HDR_LAST) begin
               hidx_d   = '0;
               cmd_load = 1'b1;
               if (w4_q == 16'd0) begin
                  if (!s_axis_tlast) begin
                     e_ll = 1'b1;
                     rx_d = RX_DROP;
                  end
               end else if (s_axis_tlast) begin
                  e_ls = 1'b1;
               end else begin
                  rx_d  = RX_PAY;
                  rem_d = w4_q;
               end
            end else if (s_axis_tlast) begin
               e_short = 1'b1;
               hidx_d  = '0;
            end
         end
         RX_PAY: if (s_beat) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
               if (s_axis_tlast) begin
                  rx_d = RX_HDR;
               end else begin
                  e_ll = 1'b1;
                  rx_d = RX_DROP;
               end
            end else if (s_axis_tlast) begin
               e_ls = 1'b1;
               rx_d = RX_HDR;
            end
         end
         RX_DROP: if (s_beat && s_axis_tlast) rx_d = RX_HDR;
         default: rx_d = RX_HDR;
      endcase
   end

   always_comb begin
      s_axis_tready = 1'b0;
      p_axis_tvalid = 1'b0;
      p_axis_tdata  = s_axis_tdata;
      p_axis_tlast  = 1'b0;
      if (aresetn) begin
         case (rx_q)
            RX_HDR:  s_axis_tready = 1'b1;
            RX_PAY: begin
               s_axis_tready = p_axis_tready;
               p_axis_tvalid = s_axis_tvalid;
               p_axis_tlast  = s_axis_tlast || (rem_q == 16'd1);
            end
            RX_DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
         endcase
      end
   end

   // ---------------- egress ----------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         tx_q     <= TX_IDLE;
         kidx_q   <= '0;
         notify_q <= 1'b0;
         for (int i = 0; i < HDR_WORDS; i++) tx_hdr_q[i] <= '0;
      end else begin
         tx_q   <= tx_d;
         kidx_q <= kidx_d;
         if (tx_q == TX_IDLE && tx_start) begin
            notify_q <= tx_notify_only;
            for (int i = 0; i < HDR_WORDS; i++)
               tx_hdr_q[i] <= tx_hdr_flat[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      tx_d   = tx_q;
      kidx_d = kidx_q;
      case (tx_q)
         TX_IDLE: if (tx_start) begin
            tx_d   = TX_HDRO;
            kidx_d = '0;
         end
         TX_HDRO: if (m_beat) begin
            if (kidx_q == HDR_LAST) begin
               kidx_d = '0;
               tx_d   = notify_q ? TX_IDLE : TX_PAY;
            end else begin
               kidx_d = kidx_q + 1'b1;
            end
         end
         TX_PAY: if (m_beat && r_axis_tlast) tx_d = TX_IDLE;
         default: tx_d = TX_IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = tx_hdr_q[kidx_q];
      m_axis_tlast  = 1'b0;
      r_axis_tready = 1'b0;
      if (aresetn) begin
         case (tx_q)
            TX_HDRO: begin
               m_axis_tvalid = 1'b1;
               m_axis_tlast  = notify_q && (kidx_q == HDR_LAST);
            end
            TX_PAY: begin
               m_axis_tdata  = r_axis_tdata;
               m_axis_tvalid = r_axis_tvalid;
               m_axis_tlast  = r_axis_tlast;
               r_axis_tready = m_axis_tready;
            end
            default: m_axis_tvalid = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_codec.sv
// Directed bench for axis_pkt_codec: ingress framing/errors, backpressure, egress framing, reset.
module tb_axis_pkt_codec;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [15:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [15:0] p_axis_tdata;
   logic        p_axis_tvalid, p_axis_tlast;
   logic        p_axis_tready = 1'b1;
   logic        cmd_valid;
   logic [7:0]  cmd_instr;
   logic [4:0]  cmd_bram_start, cmd_bram_end;
   logic [15:0] cmd_addr_start, cmd_addr_count, cmd_tag;
   logic        err_magic, err_short_hdr, err_len_short, err_len_long;
   logic [1:0]  rx_state;
   logic [95:0] tx_hdr_flat = '0;
   logic        tx_start = 1'b0, tx_notify_only = 1'b0;
   logic        tx_busy;
   logic [15:0] r_axis_tdata = '0;
   logic        r_axis_tvalid = 1'b0, r_axis_tlast = 1'b0;
   logic        r_axis_tready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast;
   logic        m_axis_tready = 1'b1;

   axis_pkt_codec dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .p_axis_tdata(p_axis_tdata), .p_axis_tvalid(p_axis_tvalid),
      .p_axis_tready(p_axis_tready), .p_axis_tlast(p_axis_tlast),
      .cmd_valid(cmd_valid), .cmd_instr(cmd_instr),
      .cmd_bram_start(cmd_bram_start), .cmd_bram_end(cmd_bram_end),
      .cmd_addr_start(cmd_addr_start), .cmd_addr_count(cmd_addr_count),
      .cmd_tag(cmd_tag),
      .err_magic(err_magic), .err_short_hdr(err_short_hdr),
      .err_len_short(err_len_short), .err_len_long(err_len_long),
      .rx_state(rx_state),
      .tx_hdr_flat(tx_hdr_flat), .tx_start(tx_start),
      .tx_notify_only(tx_notify_only), .tx_busy(tx_busy),
      .r_axis_tdata(r_axis_tdata), .r_axis_tvalid(r_axis_tvalid),
      .r_axis_tready(r_axis_tready), .r_axis_tlast(r_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0, n_mis = 0;
   logic [16:0] p_q[$], m_q[$];
   int n_cmd, n_magic, n_short, n_ls, n_ll, n_stab;
   bit prev_stall = 1'b0;
   logic [15:0] prev_data = '0;

   // Inputs change 1ns after posedge, so the negedge view is what the next edge will accept
   always @(negedge aclk) begin
      if (p_axis_tvalid && p_axis_tready) p_q.push_back({p_axis_tlast, p_axis_tdata});
      if (m_axis_tvalid && m_axis_tready) m_q.push_back({m_axis_tlast, m_axis_tdata});
      if (cmd_valid)     n_cmd++;
      if (err_magic)     n_magic++;
      if (err_short_hdr) n_short++;
      if (err_len_short) n_ls++;
      if (err_len_long)  n_ll++;
      if (!aresetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata != prev_data)) n_stab++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clr();
      p_q.delete();
      m_q.delete();
      n_cmd = 0; n_magic = 0; n_short = 0; n_ls = 0; n_ll = 0; n_stab = 0;
   endtask

   task automatic send_s(input logic [15:0] d, input logic l, input bit rnd);
      int n = 0;
      bit done = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) begin
         s_axis_tvalid = 1'b0;
         p_axis_tready = 1'($urandom_range(0, 1));
         tick();
      end
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!done && n < 200) begin
         if (rnd) p_axis_tready = 1'($urandom_range(0, 1));
         #1;
         done = s_axis_tready;
         @(posedge aclk);
         #1;
         n++;
      end
      if (!done) chk("s_timeout", 1, 0);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_hdr(input logic [15:0] w0, w1, w2, w3, w4, w5, input bit last);
      send_s(w0, 1'b0, 1'b0);
      send_s(w1, 1'b0, 1'b0);
      send_s(w2, 1'b0, 1'b0);
      send_s(w3, 1'b0, 1'b0);
      send_s(w4, 1'b0, 1'b0);
      send_s(w5, last, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drives random m_tready and an nbeats-long r stream until tx_busy drops;
   // start2_at re-pulses tx_start while that data beat is pending, abort_at returns early.
   task automatic run_tx(input int nbeats, input int start2_at, input int abort_at);
      int ri = 0, n = 0;
      bit rb;
      while (n < 400) begin
         if (!tx_busy) break;
         if (ri == abort_at) break;
         m_axis_tready = 1'($urandom_range(0, 1));
         r_axis_tvalid = (ri < nbeats);
         r_axis_tdata  = 16'h0080 + 16'(ri);
         r_axis_tlast  = (ri == nbeats - 1);
         tx_start      = (ri == start2_at);
         #1;
         rb = r_axis_tvalid && r_axis_tready;
         @(posedge aclk);
         #1;
         if (rb) ri++;
         n++;
      end
      if (n >= 400) chk("tx_timeout", 1, 0);
      tx_start      = 1'b0;
      r_axis_tvalid = 1'b0;
      r_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
   endtask

   task automatic pulse_tx(input logic notify);
      tx_notify_only = notify;
      tx_start       = 1'b1;
      tick();
      tx_start       = 1'b0;
      tx_notify_only = 1'b0;
   endtask

   initial begin
      clr();
      // reset
      idle(2);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_p_tvalid", p_axis_tvalid, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_count", cmd_addr_count, 0);
      aresetn = 1'b1;
      tick();
      chk("rst_rx_state", rx_state, 0);
      chk("hdr_s_tready", s_axis_tready, 1);

      // nominal ingress packet
      clr();
      send_hdr(16'hC0DE, 16'h0002, 16'h0041, 16'h0010, 16'h0003, 16'h0007, 1'b0);
      send_s(16'h000A, 1'b0, 1'b0);
      send_s(16'h000B, 1'b0, 1'b0);
      send_s(16'h000C, 1'b1, 1'b0);
      idle(3);
      chk("t1_cmd_valid_cnt", n_cmd, 1);
      chk("t1_instr", cmd_instr, 8'h02);
      chk("t1_bram_start", cmd_bram_start, 5'd1);
      chk("t1_bram_end", cmd_bram_end, 5'd2);
      chk("t1_addr_start", cmd_addr_start, 16'h0010);
      chk("t1_count", cmd_addr_count, 16'd3);
      chk("t1_tag", cmd_tag, 16'h0007);
      chk("t1_p_beats", p_q.size(), 3);
      if (p_q.size() == 3) begin
         chk("t1_p0", p_q[0], {1'b0, 16'h000A});
         chk("t1_p1", p_q[1], {1'b0, 16'h000B});
         chk("t1_p2", p_q[2], {1'b1, 16'h000C});
      end
      chk("t1_errors", n_magic + n_short + n_ls + n_ll, 0);
      chk("t1_rx_state", rx_state, 0);

      // bad magic, then a good packet
      clr();
      send_s(16'hBEEF, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) send_s(16'h0100 + 16'(i), (i == 8), 1'b0);
      idle(2);
      chk("t2_err_magic", n_magic, 1);
      chk("t2_p_beats", p_q.size(), 0);
      chk("t2_cmd_valid_cnt", n_cmd, 0);
      chk("t2_instr_hold", cmd_instr, 8'h02);
      chk("t2_rx_state", rx_state, 0);
      clr();
      send_hdr(16'hC0DE, 16'h0005, 16'h0000, 16'h0020, 16'h0001, 16'h0009, 1'b0);
      send_s(16'h0055, 1'b1, 1'b0);
      idle(2);
      chk("t2b_cmd_valid_cnt", n_cmd, 1);
      chk("t2b_instr", cmd_instr, 8'h05);
      chk("t2b_tag", cmd_tag, 16'h0009);
      chk("t2b_p_beats", p_q.size(), 1);
      if (p_q.size() == 1) chk("t2b_p0", p_q[0], {1'b1, 16'h0055});

      // short header
      clr();
      send_s(16'hC0DE, 1'b0, 1'b0);
      send_s(16'h0001, 1'b0, 1'b0);
      send_s(16'h0002, 1'b1, 1'b0);
      idle(2);
      chk("t3_err_short_hdr", n_short, 1);
      chk("t3_cmd_valid_cnt", n_cmd, 0);
      chk("t3_instr_hold", cmd_instr, 8'h05);

      // length too short: count 4, tlast on 2nd payload beat
      clr();
      send_hdr(16'hC0DE, 16'h0003, 16'h0000, 16'h0000, 16'h0004, 16'h0001, 1'b0);
      send_s(16'h00D0, 1'b0, 1'b0);
      send_s(16'h00D1, 1'b1, 1'b0);
      idle(2);
      chk("t4_err_len_short", n_ls, 1);
      chk("t4_p_beats", p_q.size(), 2);
      if (p_q.size() == 2) begin
         chk("t4_p0", p_q[0], {1'b0, 16'h00D0});
         chk("t4_p1", p_q[1], {1'b1, 16'h00D1});
      end
      chk("t4_rx_state", rx_state, 0);

      // length too long: count 2, five payload beats
      clr();
      send_hdr(16'hC0DE, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'h0001, 1'b0);
      for (int i = 0; i < 5; i++) send_s(16'h00E0 + 16'(i), (i == 4), 1'b0);
      idle(2);
      chk("t5_err_len_long", n_ll, 1);
      chk("t5_err_len_short", n_ls, 0);
      chk("t5_p_beats", p_q.size(), 2);
      if (p_q.size() == 2) begin
         chk("t5_p0", p_q[0], {1'b0, 16'h00E0});
         chk("t5_p1", p_q[1], {1'b1, 16'h00E1});
      end
      chk("t5_rx_state", rx_state, 0);

      // zero-count header-only packet
      clr();
      send_hdr(16'hC0DE, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b1);
      idle(2);
      chk("t6_cmd_valid_cnt", n_cmd, 1);
      chk("t6_errors", n_magic + n_short + n_ls + n_ll, 0);
      chk("t6_rx_state", rx_state, 0);

      // 64-beat payload under random backpressure and source gaps
      clr();
      send_hdr(16'hC0DE, 16'h0006, 16'h0000, 16'h0000, 16'd64, 16'h0003, 1'b0);
      for (int i = 0; i < 64; i++) send_s(16'h1000 + 16'(i), (i == 63), 1'b1);
      p_axis_tready = 1'b1;
      idle(2);
      chk("t7_p_beats", p_q.size(), 64);
      if (p_q.size() == 64)
         for (int i = 0; i < 64; i++)
            chk($sformatf("t7_p%0d", i), p_q[i], {(i == 63), 16'h1000 + 16'(i)});
      chk("t7_errors", n_magic + n_short + n_ls + n_ll, 0);

      // egress notify-only
      clr();
      for (int i = 0; i < 6; i++) tx_hdr_flat[i*16 +: 16] = 16'h0011 + 16'(i);
      pulse_tx(1'b1);
      chk("t8_busy", tx_busy, 1);
      run_tx(0, -1, -1);
      idle(2);
      chk("t8_busy_after", tx_busy, 0);
      chk("t8_m_beats", m_q.size(), 6);
      if (m_q.size() == 6)
         for (int i = 0; i < 6; i++)
            chk($sformatf("t8_m%0d", i), m_q[i], {(i == 5), 16'h0011 + 16'(i)});
      chk("t8_stable", n_stab, 0);

      // egress header + 8 data beats, second tx_start during PAY ignored
      clr();
      for (int i = 0; i < 6; i++) tx_hdr_flat[i*16 +: 16] = 16'h0021 + 16'(i);
      pulse_tx(1'b0);
      tx_hdr_flat = '1;
      run_tx(8, 3, -1);
      idle(3);
      chk("t9_busy_after", tx_busy, 0);
      chk("t9_m_beats", m_q.size(), 14);
      if (m_q.size() == 14)
         for (int i = 0; i < 14; i++)
            chk($sformatf("t9_m%0d", i), m_q[i],
                (i < 6) ? {1'b0, 16'h0021 + 16'(i)} : {(i == 13), 16'h0080 + 16'(i - 6)});
      chk("t9_stable", n_stab, 0);

      // reset in the middle of PAY
      clr();
      pulse_tx(1'b0);
      run_tx(8, -1, 2);
      chk("t10_busy_pre", tx_busy, 1);
      r_axis_tvalid = 1'b1;
      aresetn = 1'b0;
      #1;
      chk("t10_rst_m_tvalid", m_axis_tvalid, 0);
      chk("t10_rst_busy", tx_busy, 0);
      chk("t10_rst_s_tready", s_axis_tready, 0);
      tick();
      aresetn = 1'b1;
      r_axis_tvalid = 1'b0;
      tick();
      chk("t10_m_tvalid", m_axis_tvalid, 0);
      chk("t10_busy", tx_busy, 0);
      chk("t10_p_tvalid", p_axis_tvalid, 0);
      chk("t10_rx_state", rx_state, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
